// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding instruction memory reads, a small
// instruction buffer toward decode, and redirect flush. Optional: FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] current_address,
  output logic [ADDR_W-1:0] next_address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fetch_misalign
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];

  logic [ADDR_W-1:0] redirect_tgt;
  logic              fifo_full;
  logic              issue;
  logic              push;
  logic              pop;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_tgt = {redirect_addr[ADDR_W-1:2], 2'b00};
`else
  assign redirect_tgt = redirect_addr;
`endif

  assign fifo_full   = (count_q == DEPTH_C);
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    next_address = current_address;
    issue        = 1'b0;
    push         = 1'b0;

    if (!reset) begin
      next_address = RESET_ADDR;
    end else if (redirect_valid) begin
      next_address = redirect_tgt;
      // A response arriving with the redirect is the stale one, so nothing is left to drop.
      if ((state_q == S_WAIT || state_q == S_DROP) && imem_valid) begin
        state_d = S_IDLE;
      end else if (state_q == S_WAIT) begin
        state_d = S_DROP;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_full) begin
            issue        = 1'b1;
            next_address = current_address + ADDR_W'(4);
            fetch_addr_d = current_address;
            state_d      = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DROP: begin
          if (imem_valid) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imem_req  = issue;
  assign imem_addr = issue ? current_address : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_d + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_d - CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: buffer storage is not reset; outputs are masked by instr_valid, so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= fetch_addr_q;
    end
  end

  assign instr_data = instr_valid ? data_mem_q[rd_ptr_q] : '0;
  assign instr_pc   = instr_valid ? pc_mem_q[rd_ptr_q]   : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid && (redirect_addr[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: PC register, latency-varying memory model,
// and an ideal sequential instruction-stream reference that restarts on redirect/reset.
module tb_instr_fetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk            = 1'b0;
  logic          reset          = 1'b0;
  logic [AW-1:0] current_address = '0;
  logic [AW-1:0] next_address;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid     = 1'b0;
  logic [DW-1:0] imem_rdata     = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr  = '0;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready    = 1'b1;
  logic          fetch_misalign;

  instr_fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RESET_ADDR(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .current_address(current_address), .next_address(next_address),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  // Program counter register: loads next_address every cycle.
  always @(posedge clk) current_address <= next_address;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] target_of(input logic [AW-1:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
    return a & ~32'h3;
`else
    return a;
`endif
  endfunction

  // Memory model: one outstanding read, response 1..3 cycles after the request.
  bit            mem_pending = 1'b0;
  logic [AW-1:0] mem_addr    = '0;
  int            mem_left    = 0;
  int            lat_mode    = 1;   // 0: random latency, else fixed latency

  always @(negedge clk) begin
    if (imem_req) begin
      check("single_outstanding", mem_pending, 0);
      mem_pending = 1'b1;
      mem_addr    = imem_addr;
      mem_left    = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 3));
    end
  end

  always @(posedge clk) begin
    #1;
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (mem_pending) begin
      mem_left--;
      if (mem_left == 0) begin
        imem_valid  = 1'b1;
        imem_rdata  = 32'hAAAA0000 + mem_addr;
        mem_pending = 1'b0;
      end
    end
  end

  // Scoreboard: the ideal stream is consecutive word addresses from the last reset/redirect.
  logic [AW-1:0] exp_q[$];
  bit            rst_prev_low = 1'b1;
  bit            redir_prev   = 1'b0;
  bit            misalign_exp = 1'b0;
  int            pop_count    = 0;

  always @(negedge clk) begin
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_next;
    if (!reset) begin
      check("rst_next_address", next_address, 32'h0);
      check("rst_imem_req", imem_req, 0);
      if (rst_prev_low) begin
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_fetch_misalign", fetch_misalign, 0);
      end
      exp_q.delete();
      exp_q.push_back(32'h0);
      misalign_exp = 1'b0;
      rst_prev_low = 1'b1;
      redir_prev   = 1'b0;
    end else begin
      if (redir_prev) check("flush_empty", instr_valid, 0);
      check("fetch_misalign", fetch_misalign, misalign_exp);
      if (instr_valid && instr_ready) begin
        e_pc   = exp_q.pop_front();
        e_data = 32'hAAAA0000 + e_pc;
        check("instr_pc", instr_pc, e_pc);
        check("instr_data", instr_data, e_data);
        pop_count++;
      end
      if (redirect_valid) begin
        check("redirect_next_address", next_address, target_of(redirect_addr));
        check("redirect_no_req", imem_req, 0);
        exp_q.delete();
        exp_q.push_back(target_of(redirect_addr));
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_addr[1:0] != 2'b00) misalign_exp = 1'b1;
`endif
      end else if (imem_req) begin
        e_next = current_address + 32'd4;
        check("issue_addr", imem_addr, current_address);
        check("issue_next_address", next_address, e_next);
      end else begin
        check("hold_next_address", next_address, current_address);
      end
      redir_prev   = redirect_valid;
      rst_prev_low = 1'b0;
    end
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic do_redirect(input logic [AW-1:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    step(1);
    redirect_valid = 1'b0;
    redirect_addr  = $urandom;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int start = pop_count;
    int k = 0;
    while (pop_count < start + n && k < budget) begin
      step(1);
      k++;
    end
    check(name, pop_count >= start + n, 1);
  endtask

  task automatic wait_req(input int budget, input string name);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      seen = imem_req;
      k++;
    end
    check(name, seen, 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int reqs;
    int start;
    int k;
    bit found;

    // Back-to-back fetch with 1-cycle memory: one request every 2 cycles.
    lat_mode    = 1;
    instr_ready = 1'b1;
    do_reset();
    start = pop_count;
    reqs  = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req) reqs++;
    end
    @(posedge clk);
    #2;
    check("throughput_reqs", reqs, 10);
    check("throughput_pops", pop_count - start, 9);

    // Decode stalled: buffer fills to DEPTH and fetch stops, then drains in order.
    lat_mode    = 0;
    instr_ready = 1'b0;
    do_reset();
    reqs = 0;
    repeat (40) begin
      @(negedge clk);
      if (imem_req) reqs++;
    end
    check("full_reqs", reqs, DEPTH);
    check("full_no_req", imem_req, 0);
    check("full_instr_valid", instr_valid, 1);
    check("full_pc_hold", next_address, current_address);
    @(posedge clk);
    #2;
    instr_ready = 1'b1;
    wait_pops(8, 100, "full_drain_pops");

    // Redirect while waiting; the stale response arrives two cycles later.
    lat_mode = 3;
    wait_req(20, "late_drop_req_seen");
    do_redirect(32'h100);
    wait_pops(4, 60, "late_drop_pops");

    // Redirect in the same cycle as the response.
    lat_mode = 2;
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      if (imem_valid) found = 1'b1;
      else begin
        step(1);
        k++;
      end
    end
    check("same_cycle_found", found, 1);
    do_redirect(32'h40);
    wait_pops(4, 60, "same_cycle_pops");

    // Address wrap at the top of the space.
    lat_mode = 0;
    do_redirect(32'hFFFFFFFC);
    wait_pops(4, 60, "wrap_pops");

    // Misaligned redirect target.
    do_redirect(32'h102);
    wait_pops(3, 60, "misalign_pops");
    step(5);

    // Reset while a response is outstanding; the late response lands in IDLE.
    lat_mode = 3;
    wait_req(20, "reset_wait_req_seen");
    do_reset();
    wait_pops(4, 60, "reset_mid_wait_pops");

    // Random traffic: stalls, redirects, latency, one mid-run reset.
    lat_mode = 0;
    start = pop_count;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_addr  = $urandom & 32'h0000FFFC;
      step(1);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    check("random_progress", (pop_count - start) > 200, 1);
    wait_pops(4, 60, "final_pops");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
